// File: rtl/uart_pkt_deframer_pkg.sv
// Shared types and constants for the UART packet deframer.
// CRC8_POLY is used only when UART_PKT_DEFRAMER_CRC8_EN is defined.
package uart_pkt_deframer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK
    } state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_CHK  = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_LINE = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    // MSB-first CRC-8 over one byte, no reflection, no final XOR
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_pkt_deframer_chk.sv
// Payload check accumulator: 8-bit modular sum, or CRC-8 when
// UART_PKT_DEFRAMER_CRC8_EN is defined.
module uart_pkt_chk
    import uart_pkt_deframer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic [7:0] nxt;

`ifdef UART_PKT_DEFRAMER_CRC8_EN
    assign nxt = crc8_byte(acc_q, data_i);
`else
    assign nxt = acc_q + data_i;
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_q;

endmodule

// File: rtl/uart_pkt_deframer.sv
// Assembles SOF/LEN/payload/CHK frames from a UART receive byte stream.
// Build option: UART_PKT_DEFRAMER_CRC8_EN selects CRC-8 over modular sum.
module uart_pkt_deframer
    import uart_pkt_deframer_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 10000
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    input  logic       RX_ERR,
    input  logic       RX_OVERFLOW,
    output logic [7:0] PL_DATA,
    output logic       PL_VALID,
    output logic       PL_SOP,
    output logic       PL_EOP,
    output logic       PKT_DONE,
    output logic       PKT_OK,
    output logic [2:0] ERR_CODE,
    output logic       BUSY
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          first_q, first_d;

    logic       acc_clr, acc_en;
    logic [7:0] acc;
    logic       ev_abort, ev_emit, ev_chk;
    logic [2:0] ev_code;

    logic [7:0] pl_data_q, pl_data_d;
    logic       pl_valid_q, pl_valid_d;
    logic       pl_sop_q, pl_sop_d;
    logic       pl_eop_q, pl_eop_d;
    logic       done_q, done_d;
    logic       ok_q, ok_d;
    logic [2:0] code_q, code_d;
    logic       busy_q, busy_d;

    uart_pkt_chk u_chk (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .data_i (RX_DATA),
        .sum_o  (acc)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            tmo_q      <= '0;
            first_q    <= 1'b0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_sop_q   <= 1'b0;
            pl_eop_q   <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            code_q     <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            first_q    <= first_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_sop_q   <= pl_sop_d;
            pl_eop_q   <= pl_eop_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
        end
    end

    // Precedence inside a frame: overflow, then byte, then timeout
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        first_d  = first_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        ev_abort = 1'b0;
        ev_code  = ERR_NONE;
        ev_emit  = 1'b0;
        ev_chk   = 1'b0;
        if (state_q == IDLE) begin
            if (RX_VALID && !RX_ERR && RX_DATA == SOF_BYTE) begin
                state_d = LEN;
                acc_clr = 1'b1;
                tmo_d   = TMO_LOAD;
            end
        end else if (RX_OVERFLOW) begin
            ev_abort = 1'b1;
            ev_code  = ERR_LINE;
        end else if (RX_VALID) begin
            tmo_d = TMO_LOAD;
            unique case (state_q)
                LEN: begin
                    if (RX_ERR) begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_LINE;
                    end else if (RX_DATA > MAX_LEN_B) begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_LEN;
                    end else if (RX_DATA == 8'd0) begin
                        state_d = CHK;
                    end else begin
                        rem_d   = RX_DATA;
                        first_d = 1'b1;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (RX_ERR) begin
                        ev_abort = 1'b1;
                        ev_code  = ERR_LINE;
                    end else begin
                        ev_emit = 1'b1;
                        acc_en  = 1'b1;
                        first_d = 1'b0;
                        rem_d   = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    ev_chk  = 1'b1;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end else if (tmo_q <= TW'(1)) begin
            ev_abort = 1'b1;
            ev_code  = ERR_TMO;
        end else begin
            tmo_d = tmo_q - TW'(1);
        end
        if (ev_abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        pl_valid_d = ev_emit;
        pl_data_d  = ev_emit ? RX_DATA : 8'd0;
        pl_sop_d   = ev_emit && first_q;
        pl_eop_d   = ev_emit && (rem_q == 8'd1);
        done_d     = ev_abort || ev_chk;
        ok_d       = 1'b0;
        code_d     = ERR_NONE;
        busy_d     = (state_d != IDLE);
        if (ev_abort) begin
            code_d = ev_code;
        end else if (ev_chk) begin
            if (RX_ERR) begin
                code_d = ERR_LINE;
            end else if (RX_DATA == acc) begin
                ok_d = 1'b1;
            end else begin
                code_d = ERR_CHK;
            end
        end
    end

    assign PL_DATA  = pl_data_q;
    assign PL_VALID = pl_valid_q;
    assign PL_SOP   = pl_sop_q;
    assign PL_EOP   = pl_eop_q;
    assign PKT_DONE = done_q;
    assign PKT_OK   = ok_q;
    assign ERR_CODE = code_q;
    assign BUSY     = busy_q;

endmodule
